// File: rtl/program_loader_pkg.sv
// Shared types and default response bytes for the UART program loader.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV_COUNT,
        RECV_WORD,
        WRITE,
        ACK,
        DONE,
        ERROR
    } state_e;

    localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hAA;
    localparam logic [7:0] DEFAULT_NAK_BYTE = 8'h55;

endpackage

// File: rtl/program_loader_byte_to_word_assembler.sv
// Big-endian byte-to-word shifter; flags the fourth byte of each word combinationally
// so the caller can capture the complete word in the same cycle.
module byte_to_word_assembler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  count_q, count_d;

    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        if (clear_i) begin
            shift_d = '0;
            count_d = '0;
        end else if (byte_valid_i) begin
            shift_d = {shift_q[23:0], byte_data_i};
            count_d = count_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    // Clear takes priority so a byte arriving with a restart is discarded.
    assign word_o       = {shift_q[23:0], byte_data_i};
    assign word_valid_o = byte_valid_i && !clear_i && (count_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Boot loader: frames a UART byte stream (count N, then N words) into program-memory
// writes, answers with ACK/NAK and keeps the core in reset until the load is done.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         PROGRAM_MEMORY_ADDRESS_BITWIDTH = 15,
    parameter logic [7:0] ACK_BYTE                        = DEFAULT_ACK_BYTE,
    parameter logic [7:0] NAK_BYTE                        = DEFAULT_NAK_BYTE
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic                                       start,
    input  logic [7:0]                                 rx_data,
    input  logic                                       rx_valid,
    output logic [7:0]                                 tx_data,
    output logic                                       tx_valid,
    input  logic                                       tx_ready,
    output logic [PROGRAM_MEMORY_ADDRESS_BITWIDTH-1:0] pm_write_address,
    output logic [31:0]                                pm_write_data,
    output logic                                       pm_write_enable,
    output logic                                       core_hold,
    output logic                                       load_done,
    output logic                                       load_error
);

    localparam int          AW       = PROGRAM_MEMORY_ADDRESS_BITWIDTH;
    localparam int          IDX_W    = AW - 2;
    localparam logic [32:0] CAPACITY = 33'd1 << IDX_W;

    state_e              state_q, state_d;
    logic [31:0]         count_q, count_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic                err_q, err_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                pm_we_q, pm_we_d;
    logic [AW-1:0]       pm_addr_q, pm_addr_d;
    logic [31:0]         pm_data_q, pm_data_d;

    logic                start_ok;
    logic                asm_valid;
    logic [31:0]         asm_word;
    logic                asm_word_valid;
    logic                last_word;

    assign start_ok  = start && (state_q inside {IDLE, DONE, ERROR});
    assign asm_valid = rx_valid && (state_q inside {RECV_COUNT, RECV_WORD, WRITE});
    assign last_word = ((33'(index_q) + 33'd1) == {1'b0, count_q});

    byte_to_word_assembler u_assembler (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (start_ok),
        .byte_valid_i (asm_valid),
        .byte_data_i  (rx_data),
        .word_o       (asm_word),
        .word_valid_o (asm_word_valid)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        index_d   = index_q;
        err_d     = err_q;
        tx_data_d = tx_data_q;
        pm_we_d   = 1'b0;
        pm_addr_d = '0;
        pm_data_d = '0;

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_ok) begin
                    state_d = RECV_COUNT;
                    count_d = '0;
                    index_d = '0;
                    err_d   = 1'b0;
                end
            end
            RECV_COUNT: begin
                if (asm_word_valid) begin
                    count_d = asm_word;
                    index_d = '0;
                    if (asm_word == 32'd0) begin
                        state_d   = ACK;
                        tx_data_d = ACK_BYTE;
                    end else if ({1'b0, asm_word} > CAPACITY) begin
                        state_d   = ACK;
                        tx_data_d = NAK_BYTE;
                        err_d     = 1'b1;
                    end else begin
                        state_d = RECV_WORD;
                    end
                end
            end
            RECV_WORD: begin
                // The write-port registers double as the holding register for the word,
                // so the assembler is free to accept the next byte during WRITE.
                if (asm_word_valid) begin
                    state_d   = WRITE;
                    pm_we_d   = 1'b1;
                    pm_addr_d = {index_q, 2'b00};
                    pm_data_d = asm_word;
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_d   = ACK;
                    tx_data_d = ACK_BYTE;
                end else begin
                    state_d = RECV_WORD;
                    index_d = index_q + 1'b1;
                end
            end
            ACK: begin
                if (tx_ready) begin
                    state_d   = err_q ? ERROR : DONE;
                    tx_data_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            index_q   <= '0;
            err_q     <= 1'b0;
            tx_data_q <= '0;
            pm_we_q   <= 1'b0;
            pm_addr_q <= '0;
            pm_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            index_q   <= index_d;
            err_q     <= err_d;
            tx_data_q <= tx_data_d;
            pm_we_q   <= pm_we_d;
            pm_addr_q <= pm_addr_d;
            pm_data_q <= pm_data_d;
        end
    end

    assign tx_data          = tx_data_q;
    assign tx_valid         = (state_q == ACK);
    assign pm_write_enable  = pm_we_q;
    assign pm_write_address = pm_addr_q;
    assign pm_write_data    = pm_data_q;
    assign core_hold        = (state_q != DONE);
    assign load_done        = (state_q == DONE);
    assign load_error       = (state_q == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed + randomized bench for program_loader: a full-size (W=15) and a small (W=6)
// instance, selected by sel, checked against a queue-based model of the load protocol.
module tb_program_loader;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b1;
    logic       sel      = 1'b0;
    logic       start    = 1'b0;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data  = 8'h00;

    logic        start_l, rxv_l, txr_l, start_s, rxv_s, txr_s;
    logic [7:0]  txd_l, txd_s;
    logic        txv_l, txv_s, we_l, we_s, hold_l, hold_s, done_l, done_s, err_l, err_s;
    logic [14:0] addr_l;
    logic [5:0]  addr_s;
    logic [31:0] data_l, data_s;

    logic [7:0]  obs_txd;
    logic        obs_txv, obs_we, obs_hold, obs_done, obs_err;
    logic [15:0] obs_addr;
    logic [31:0] obs_data;

    assign start_l = start & ~sel;
    assign rxv_l   = rx_valid & ~sel;
    assign txr_l   = tx_ready & ~sel;
    assign start_s = start & sel;
    assign rxv_s   = rx_valid & sel;
    assign txr_s   = tx_ready & sel;

    assign obs_txd  = sel ? txd_s  : txd_l;
    assign obs_txv  = sel ? txv_s  : txv_l;
    assign obs_we   = sel ? we_s   : we_l;
    assign obs_hold = sel ? hold_s : hold_l;
    assign obs_done = sel ? done_s : done_l;
    assign obs_err  = sel ? err_s  : err_l;
    assign obs_addr = sel ? {10'b0, addr_s} : {1'b0, addr_l};
    assign obs_data = sel ? data_s : data_l;

    program_loader #(.PROGRAM_MEMORY_ADDRESS_BITWIDTH(15)) dut (
        .clk(clk), .reset_n(reset_n), .start(start_l), .rx_data(rx_data), .rx_valid(rxv_l),
        .tx_data(txd_l), .tx_valid(txv_l), .tx_ready(txr_l), .pm_write_address(addr_l),
        .pm_write_data(data_l), .pm_write_enable(we_l), .core_hold(hold_l),
        .load_done(done_l), .load_error(err_l)
    );

    program_loader #(.PROGRAM_MEMORY_ADDRESS_BITWIDTH(6)) dut_small (
        .clk(clk), .reset_n(reset_n), .start(start_s), .rx_data(rx_data), .rx_valid(rxv_s),
        .tx_data(txd_s), .tx_valid(txv_s), .tx_ready(txr_s), .pm_write_address(addr_s),
        .pm_write_data(data_s), .pm_write_enable(we_s), .core_hold(hold_s),
        .load_done(done_s), .load_error(err_s)
    );

    always #5 clk = ~clk;

    // Write-port monitor: logs every strobe, and counts cycles where the idle port is non-zero.
    logic [15:0] wr_addr [0:4095];
    logic [31:0] wr_data [0:4095];
    int          wr_cnt   = 0;
    int          idle_bad = 0;

    always @(negedge clk) begin
        if (obs_we === 1'b1) begin
            wr_addr[wr_cnt % 4096] <= obs_addr;
            wr_data[wr_cnt % 4096] <= obs_data;
            wr_cnt <= wr_cnt + 1;
        end else if (obs_addr !== 16'h0 || obs_data !== 32'h0) begin
            idle_bad <= idle_bad + 1;
        end
    end

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] stim_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], $urandom_range(0, gap_max));
    endtask

    task automatic fill_random(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back($urandom);
    endtask

    // Model: N==0 -> ACK, N>capacity -> NAK and error, else word i lands at byte address 4*i.
    task automatic run_load(input logic [31:0] n, input int gap_max, input int stall, input bit collide);
        int         base, exp_w, cap, got;
        logic [7:0] exp_tx;
        bit         exp_err, seen;
        cap  = sel ? 16 : 8192;
        base = wr_cnt;
        start = 1'b1;
        if (collide) begin
            rx_valid = 1'b1;
            rx_data  = 8'hFF;
        end
        tick();
        start    = 1'b0;
        rx_valid = 1'b0;
        check("hold_on_start", obs_hold, 1);
        check("done_clear_on_start", obs_done, 0);
        send_word(n, gap_max);
        if (n == 32'd0) begin
            exp_w = 0; exp_tx = 8'hAA; exp_err = 1'b0;
        end else if (n > 32'(cap)) begin
            exp_w = 0; exp_tx = 8'h55; exp_err = 1'b1;
        end else begin
            exp_w = int'(n); exp_tx = 8'hAA; exp_err = 1'b0;
        end
        for (int i = 0; i < exp_w; i++) send_word(stim_q[i], gap_max);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (obs_txv === 1'b1) seen = 1'b1;
            else tick();
        end
        check("ack_seen", seen, 1);
        for (int k = 0; k < stall; k++) begin
            check("stall_tx_valid", obs_txv, 1);
            check("stall_tx_data", obs_txd, exp_tx);
            tick();
        end
        check("tx_data", obs_txd, exp_tx);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("tx_valid_drop", obs_txv, 0);
        check("load_done", obs_done, !exp_err);
        check("load_error", obs_err, exp_err);
        check("core_hold", obs_hold, exp_err);
        got = wr_cnt - base;
        check("write_count", got, exp_w);
        for (int i = 0; i < exp_w && i < got; i++) begin
            check("write_addr", wr_addr[(base + i) % 4096], 4 * i);
            check("write_data", wr_data[(base + i) % 4096], stim_q[i]);
        end
        $display("load sel=%0d N=%0d gap<=%0d stall=%0d tx=%02h writes=%0d", sel, n, gap_max, stall, exp_tx, got);
    endtask

    initial begin
        int base;
        #1 reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("rst_core_hold", obs_hold, 1);
        check("rst_tx_valid", obs_txv, 0);
        check("rst_tx_data", obs_txd, 0);
        check("rst_we", obs_we, 0);
        check("rst_addr", obs_addr, 0);
        check("rst_data", obs_data, 0);
        check("rst_done", obs_done, 0);
        check("rst_error", obs_err, 0);

        // Bytes before start must be ignored.
        base = wr_cnt;
        for (int i = 0; i < 12; i++) send_byte(8'($urandom), 0);
        check("idle_no_write", wr_cnt - base, 0);
        check("idle_no_tx", obs_txv, 0);
        check("idle_hold", obs_hold, 1);

        stim_q.delete();
        stim_q.push_back(32'h12345678);
        stim_q.push_back(32'h9ABCDEF0);
        run_load(32'd2, 0, 0, 1'b0);

        stim_q.delete();
        run_load(32'd0, 1, 0, 1'b0);

        // Restart from DONE with a colliding byte that must be dropped.
        stim_q.delete();
        stim_q.push_back(32'hDEADBEEF);
        run_load(32'd1, 0, 2, 1'b1);

        // Asynchronous reset in the middle of a word.
        base = wr_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_word(32'd3, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_hold", obs_hold, 1);
        check("midrst_we", obs_we, 0);
        check("midrst_tx_valid", obs_txv, 0);
        check("midrst_done", obs_done, 0);
        tick();
        reset_n = 1'b1;
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        repeat (3) tick();
        check("midrst_no_write", wr_cnt - base, 0);

        fill_random(5);
        run_load(32'd5, 2, 5, 1'b0);

        sel = 1'b1;
        tick();
        stim_q.delete();
        run_load(32'd17, 0, 1, 1'b0);
        fill_random(16);
        run_load(32'd16, 0, 5, 1'b0);
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(0, 20);
            if (n <= 16) fill_random(n);
            else stim_q.delete();
            run_load(32'(n), $urandom_range(0, 2), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        tick();
        check("idle_port_zero", idle_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time controller that fills the CPU program memory from a UART byte stream.
- Frames incoming bytes into a word count and 32-bit instruction words, drives the program-memory write port (byte address, data, enable), and returns an ACK/NAK byte.
- Holds the core in reset (core_hold) until loading completes.
- Sits between uart_rx/uart_tx and the program-memory write port; the CPU fetch side of the memory is untouched.

Parameters:
- PROGRAM_MEMORY_ADDRESS_BITWIDTH, 15, byte-address width of program memory; capacity = 2^(W-2) words.
- ACK_BYTE, 8'hAA, byte sent on successful load.
- NAK_BYTE, 8'h55, byte sent when the count exceeds capacity.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; begins a load; honoured only in IDLE, DONE or ERROR
- rx_data  input  8  received UART byte
- rx_valid  input  1  single-cycle strobe; rx_data is valid this cycle
- tx_data  output  8  byte to transmit
- tx_valid  output  1  tx_data valid; held until tx_ready
- tx_ready  input  1  transmitter accepts a byte when tx_valid && tx_ready
- pm_write_address  output  W  byte address to program memory, always word-aligned
- pm_write_data  output  32  assembled instruction word
- pm_write_enable  output  1  one-cycle write strobe
- core_hold  output  1  high while the CPU must stay in reset
- load_done  output  1  high in DONE
- load_error  output  1  high in ERROR

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0 except core_hold=1; counters and shift register cleared. Deasserting reset mid-load restarts from IDLE.
- Byte framing: big-endian, MSB first. Each accepted byte shifts in as word = {word[23:0], rx_data}; a 2-bit byte counter wraps 3→0.
- Stream format: 4-byte word count N, then N words.
- IDLE: start → RECV_COUNT. rx_valid is ignored.
- RECV_COUNT: on the 4th byte, latch N. Then:
  - N == 0 → ACK with tx_data=ACK_BYTE.
  - N > 2^(W-2) → ACK with tx_data=NAK_BYTE, error flag set.
  - Otherwise → RECV_WORD, word_index=0.
- RECV_WORD: on the 4th byte → WRITE on the next cycle.
- WRITE (exactly one cycle):
  - pm_write_enable=1, pm_write_data=the assembled word, pm_write_address={word_index, 2'b00}.
  - word_index increments.
  - If word_index+1 == N → ACK with ACK_BYTE; else → RECV_WORD.
  - An rx_valid in the WRITE cycle is captured as byte 0 of the next word, so no byte is lost. The assembled word is held in a separate register.
- ACK: tx_valid=1 with tx_data stable until tx_ready. On handshake → DONE, or → ERROR if the error flag is set. rx_valid is ignored.
- DONE: load_done=1, core_hold=0.
- ERROR: load_error=1, core_hold=1.
- start in DONE or ERROR → RECV_COUNT: core_hold=1 the next cycle, flags cleared, byte counter cleared. start in any other state is ignored.
- pm_write_enable, pm_write_address and pm_write_data are registered outputs. Address and data return to 0 when enable is low.
- Boundary cases:
  - N == capacity is legal; the last address is 2^W-4.
  - word_index never exceeds N-1.
  - Simultaneous start and rx_valid in DONE: start wins and the byte is dropped.

Decomposition:
- Package program_loader_pkg holds the state enum (IDLE, RECV_COUNT, RECV_WORD, WRITE, ACK, DONE, ERROR) and the ACK/NAK default constants.
- One sub-module, byte_to_word_assembler: shift register, 2-bit byte counter, word_valid pulse on the 4th byte, synchronous clear.
- The FSM, index counter and write port stay in the top module.

Test Plan:
- Reset during RECV_WORD → next cycle state IDLE, core_hold=1, pm_write_enable=0, tx_valid=0.
- start; bytes 00 00 00 02, 12 34 56 78, 9A BC DE F0 → writes (addr 0x0000, 0x12345678) then (0x0004, 0x9ABCDEF0), one cycle each; tx_data=AA; with tx_ready=1, load_done=1 and core_hold=0.
- start; count 00 00 00 00 → no write strobe, ACK AA, DONE.
- W=6 (16 words): count 00 00 00 11 → NAK 55, load_error=1, core_hold=1, no writes. Count 00 00 00 10 with 16 words → last write at addr 0x3C.
- Back-to-back rx_valid every cycle, including the WRITE cycle → all words correct, no dropped byte. tx_ready held 0 for 5 cycles → tx_valid and tx_data stay stable.
- After DONE, a second start plus a 1-word load of DEADBEEF → core_hold reasserts, addr 0 rewritten, DONE again. rx_valid in IDLE before start produces no writes.
